pipe_ctrl: RTL



---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/pipe_ctrl_stall_merge.sv | 32 +++
 rtl/pipe_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit.
// Latency: none (constants and types only).
// Backpressure: not applicable.
// Contents: stage index constants, multi-cycle FSM state encoding, NOP control word.
package pipe_ctrl_pkg;

  // Pipeline register indices: 0 is the PC, then the inter-stage registers.
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_WB     = 4;

  // Multi-cycle operation tracker states.
  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_DONE = 2'd2
  } mc_state_t;

  // Control word loaded into a register that is bubbled or flushed.
  localparam logic [31:0] NOP_CTRL = 32'h0000_0000;

endpackage

// File: rtl/pipe_ctrl_stall_merge.sv
// Priority merge of per-register hold requests into stall and bubble vectors.
// Latency: purely combinational.
// Backpressure: the highest requesting register and everything upstream of it hold.
// Ports: i_req  - bit k set when register k must hold
//        o_stall - bit j set for every j <= highest requested index
//        o_bubble - single bit just downstream of the highest held register
module pipe_ctrl_stall_merge #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_stall,
  output logic [N-1:0] o_bubble
);

  logic w_acc;

  always_comb begin
    w_acc    = 1'b0;
    o_stall  = '0;
    o_bubble = '0;
    // Suffix-OR from the top: a register holds if it or anything downstream holds.
    for (int j = N - 1; j >= 0; j--) begin
      w_acc      = w_acc | i_req[j];
      o_stall[j] = w_acc;
    end
    // The first non-held register after the held block receives the bubble.
    for (int j = 1; j < N; j++) begin
      o_bubble[j] = o_stall[j-1] & ~o_stall[j];
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: merges stall requests, multi-cycle-op stall and flush into strobes.
// Latency: strobes are combinational; FSM and stall counter update on the rising edge.
// Backpressure: stall requests hold upstream registers; flush overrides all holds.
// Ports: clk/rst_n clock and async active-low reset; stallreq_i per-register hold requests;
//        mc_start_i multi-cycle op start; flush_i/flush_pc_i redirect; stall_o/bubble_o/flush_o
//        per-register strobes; new_pc_vld_o/new_pc_o redirect to PC; mc_busy_o/mc_done_o op
//        status; stall_cnt_o saturating count of PC-stall cycles.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGE = 5,
  parameter int MC_IDX = STG_ID_EX,
  parameter int MC_LAT = 4,
  parameter int FL_IDX = STG_EX_MEM,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NSTAGE-1:0] stallreq_i,
  input  logic              mc_start_i,
  input  logic              flush_i,
  input  logic [31:0]       flush_pc_i,
  output logic [NSTAGE-1:0] stall_o,
  output logic [NSTAGE-1:0] bubble_o,
  output logic [NSTAGE-1:0] flush_o,
  output logic              new_pc_vld_o,
  output logic [31:0]       new_pc_o,
  output logic              mc_busy_o,
  output logic              mc_done_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int MCW = (MC_LAT > 2) ? $clog2(MC_LAT) : 1;

  mc_state_t         r_state, w_state_nxt;
  logic [MCW-1:0]    r_mc_cnt, w_mc_cnt_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [NSTAGE-1:0] w_req, w_merge_stall, w_merge_bubble, w_flush_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MC_IDLE;
      r_mc_cnt <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_mc_cnt <= w_mc_cnt_nxt;
    end
  end

  // The start cycle itself is not stalled; BUSY covers MC_LAT-2 cycles and
  // the counter reaches 0 on entry to DONE. With MC_LAT=2 there is no BUSY.
  always_comb begin
    w_state_nxt  = r_state;
    w_mc_cnt_nxt = r_mc_cnt;
    if (flush_i) begin
      w_state_nxt  = MC_IDLE;
      w_mc_cnt_nxt = '0;
    end else begin
      case (r_state)
        MC_IDLE, MC_DONE: begin
          if (mc_start_i) begin
            if (MC_LAT == 2) begin
              w_state_nxt  = MC_DONE;
              w_mc_cnt_nxt = '0;
            end else begin
              w_state_nxt  = MC_BUSY;
              w_mc_cnt_nxt = MCW'(MC_LAT - 2);
            end
          end else if (r_state == MC_DONE) begin
            w_state_nxt = MC_IDLE;
          end
        end
        MC_BUSY: begin
          w_mc_cnt_nxt = r_mc_cnt - MCW'(1);
          if (r_mc_cnt == MCW'(1)) begin
            w_state_nxt = MC_DONE;
          end
        end
        default: begin
          w_state_nxt  = MC_IDLE;
          w_mc_cnt_nxt = '0;
        end
      endcase
    end
  end

  always_comb begin
    w_req = stallreq_i;
    if (r_state == MC_BUSY) begin
      w_req[MC_IDX] = 1'b1;
    end
    for (int j = 0; j < NSTAGE; j++) begin
      w_flush_mask[j] = (j >= 1) && (j < FL_IDX);
    end
  end

  pipe_ctrl_stall_merge #(
    .N (NSTAGE)
  ) u_stall_merge (
    .i_req    (w_req),
    .o_stall  (w_merge_stall),
    .o_bubble (w_merge_bubble)
  );

  // Reset gates every strobe so nothing downstream moves while rst_n is low.
  always_comb begin
    stall_o      = '0;
    bubble_o     = '0;
    flush_o      = '0;
    new_pc_vld_o = 1'b0;
    new_pc_o     = NOP_CTRL;
    mc_busy_o    = 1'b0;
    mc_done_o    = 1'b0;
    if (rst_n) begin
      mc_busy_o = (r_state == MC_BUSY);
      if (flush_i) begin
        flush_o      = w_flush_mask;
        new_pc_vld_o = 1'b1;
        new_pc_o     = flush_pc_i;
      end else begin
        stall_o   = w_merge_stall;
        bubble_o  = w_merge_bubble;
        mc_done_o = (r_state == MC_DONE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (stall_o[STG_PC] && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall_cnt_o = r_stall_cnt;

endmodule
